// File: rtl/video_capture_if.sv
// Video capture bundle: raw timing/pixel inputs from the source, captured
// pixel stream plus sync status back to the consumer.
interface video_capture_if;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [15:0] video_rgb;

  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        frame_start;
  logic        locked;
  logic        timing_err;
  logic [10:0] h_meas;
  logic [10:0] v_meas;

  // Video source side
  modport master (
    output video_hs, video_vs, video_de, video_rgb,
    input  pixel_valid, pixel_data, pixel_xpos, pixel_ypos,
           frame_start, locked, timing_err, h_meas, v_meas
  );

  // Capture block side
  modport slave (
    input  video_hs, video_vs, video_de, video_rgb,
    output pixel_valid, pixel_data, pixel_xpos, pixel_ypos,
           frame_start, locked, timing_err, h_meas, v_meas
  );
endinterface

// File: rtl/video_capture.sv
// video_capture: samples raw video timing once, tracks pixel/line position,
// measures line and frame geometry and qualifies pixels through a lock FSM.
//
// state  | meaning
// SEARCH | no frame start seen since reset; pixels are never passed on
// SYNCED | frame boundary known; pixels passed, geometry not yet trusted
// LOCKED | last frame matched H_DISP x V_DISP; violations flag timing_err
module video_capture #(
  parameter logic [10:0] H_DISP = 11'd1024,
  parameter logic [10:0] V_DISP = 11'd768
) (
  input  logic           pixel_clk,
  input  logic           sys_rst_n,
  video_capture_if.slave vid
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNCED = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] CNT_MAX = 11'h7FF;

  logic        hs_s1_q, vs_s1_q, de_s1_q;
  logic [15:0] rgb_s1_q;
  logic        vs_prev_q, de_prev_q;

  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        line_bad_q, line_bad_d;

  state_t      state_q, state_d;

  logic        pixel_valid_q, pixel_valid_d;
  logic [15:0] pixel_data_q;
  logic [10:0] pixel_xpos_q, pixel_ypos_q;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        timing_err_q, timing_err_d;

  logic        frame_fall, line_end, de_in_vs;
  logic        h_bad, v_bad, lock_err;
  logic [10:0] x_inc, y_inc, v_new;

  // hsync carries no information the DE-based line tracking needs
  logic        unused_hs;
  assign unused_hs = hs_s1_q;

  // Stage S1: one register on every input, plus a delayed copy for edge detect
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      de_s1_q   <= 1'b0;
      rgb_s1_q  <= '0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      hs_s1_q   <= vid.video_hs;
      vs_s1_q   <= vid.video_vs;
      de_s1_q   <= vid.video_de;
      rgb_s1_q  <= vid.video_rgb;
      vs_prev_q <= vs_s1_q;
      de_prev_q <= de_s1_q;
    end
  end

  assign frame_fall = vs_prev_q & ~vs_s1_q;
  assign line_end   = de_prev_q & ~de_s1_q;
  assign de_in_vs   = de_s1_q & ~vs_s1_q;

  assign x_inc = (x_q == CNT_MAX) ? x_q : x_q + 11'd1;
  assign y_inc = (y_q == CNT_MAX) ? y_q : y_q + 11'd1;
  // A line ending on the frame-start cycle still belongs to the old frame
  assign v_new = line_end ? y_inc : y_q;

  assign h_bad    = line_end && (x_q != H_DISP);
  assign v_bad    = frame_fall && (v_new != V_DISP);
  assign lock_err = h_bad | v_bad | de_in_vs;

  // Position counters, geometry measurement and per-frame bad-line flag
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    h_meas_d   = h_meas_q;
    v_meas_d   = v_meas_q;
    line_bad_d = line_bad_q;
    if (line_end) h_meas_d = x_q;
    if (frame_fall) begin
      x_d        = '0;
      y_d        = '0;
      v_meas_d   = v_new;
      line_bad_d = 1'b0;
    end else if (line_end) begin
      x_d = '0;
      y_d = y_inc;
      if (h_bad) line_bad_d = 1'b1;
    end else if (de_s1_q) begin
      x_d = x_inc;
    end
  end

  // Counter and measurement registers
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      h_meas_q   <= '0;
      v_meas_q   <= '0;
      line_bad_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      h_meas_q   <= h_meas_d;
      v_meas_q   <= v_meas_d;
      line_bad_q <= line_bad_d;
    end
  end

  // FSM state register
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= SEARCH;
    else            state_q <= state_d;
  end

  // FSM next state; the closing line of a frame is judged on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: if (frame_fall) state_d = SYNCED;
      SYNCED: if (frame_fall && (v_new == V_DISP) && !line_bad_q && !h_bad)
                state_d = LOCKED;
      LOCKED: if (lock_err) state_d = SYNCED;
      default: state_d = SEARCH;
    endcase
  end

  // FSM outputs; all error sources merge into one pulse
  always_comb begin
    timing_err_d  = (state_q == LOCKED) && lock_err;
    locked_d      = (state_d == LOCKED);
    frame_start_d = frame_fall;
    pixel_valid_d = de_s1_q && (state_q != SEARCH) &&
                    (x_q < H_DISP) && (y_q < V_DISP);
  end

  // Output registers, all driven from S1
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_xpos_q  <= '0;
      pixel_ypos_q  <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= rgb_s1_q;
      pixel_xpos_q  <= x_q;
      pixel_ypos_q  <= y_q;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign vid.pixel_valid = pixel_valid_q;
  assign vid.pixel_data  = pixel_data_q;
  assign vid.pixel_xpos  = pixel_xpos_q;
  assign vid.pixel_ypos  = pixel_ypos_q;
  assign vid.frame_start = frame_start_q;
  assign vid.locked      = locked_q;
  assign vid.timing_err  = timing_err_q;
  assign vid.h_meas      = h_meas_q;
  assign vid.v_meas      = v_meas_q;

endmodule
